mem_arbiter: RTL and testbench



---
 rtl/mem_arbiter_pkg.sv | 27 ++
 rtl/mem_arbiter_rr_arb2.sv | 23 ++
 rtl/mem_arbiter.sv | 157 +++++++++++++++
 tb/tb_mem_arbiter.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-master data-memory arbiter.
//   arb_state_e : sequencer state encodings
//   M_CPU/M_DMA : master ids (CPU data port, DMA/debug loader)
//   CNT_W       : width of the read-latency down-counter
//   arb_ctl_t   : latched per-transaction control flags
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2,
    ARB_DONE  = 2'd3
  } arb_state_e;

  localparam logic M_CPU = 1'b0;
  localparam logic M_DMA = 1'b1;

  localparam int unsigned CNT_W = 4;

  // Control half of a granted request; address/data widths are per instance.
  typedef struct packed {
    logic we;
    logic is_byte;
    logic id;
  } arb_ctl_t;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-input round-robin picker (combinational).
//   req        : request vector, bit 0 = M_CPU, bit 1 = M_DMA
//   last_grant : id of the most recent winner (register lives in the parent)
//   grant_c    : winning id; only meaningful when req != 0
module mem_arbiter_rr_arb2
  import mem_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant_c
);

  // Tie goes to whichever master did not win last time.
  always_comb begin
    grant_c = M_CPU;
    if (req == 2'b11) begin
      grant_c = ~last_grant;
    end else if (req[1]) begin
      grant_c = M_DMA;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master arbiter/sequencer in front of the single-port data memory.
//   clk, rst              : clock, synchronous active-high reset
//   m0_* / m1_*           : CPU and DMA request ports (req held until ack),
//                           one-cycle ack, rdata valid with ack
//   mem_en/we/byte/addr/wdata : memory command, mem_en high one cycle per access
//   mem_rdata             : memory read data, valid LAT cycles after mem_en
//   busy                  : high whenever the sequencer is not idle
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned AW  = 32,
  parameter int unsigned DW  = 32,
  parameter int unsigned LAT = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic          m0_byte,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_ack,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic          m1_byte,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_ack,
  output logic [DW-1:0] m1_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic          mem_byte,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  // ISSUE itself is the first latency cycle, so WAIT counts down from LAT-1.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LAT - 1);

  arb_state_e       state_q, state_d;
  arb_ctl_t         ctl_q, ctl_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [DW-1:0]    wdata_q, wdata_d;
  logic [DW-1:0]    rdata_q, rdata_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_grant_q, last_grant_d;
  logic             grant_c;
  logic             mem_en_d, mem_we_d, m0_ack_d, m1_ack_d, busy_d;

  mem_arbiter_rr_arb2 u_rr_arb2 (
    .req        ({m1_req, m0_req}),
    .last_grant (last_grant_q),
    .grant_c    (grant_c)
  );

  // Next-state, latch and registered-output decode.
  always_comb begin
    state_d      = state_q;
    ctl_d        = ctl_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;

    case (state_q)
      ARB_IDLE: begin
        if (m0_req || m1_req) begin
          last_grant_d = grant_c;
          ctl_d.id     = grant_c;
          if (grant_c == M_DMA) begin
            ctl_d.we      = m1_we;
            ctl_d.is_byte = m1_byte;
            addr_d        = m1_addr;
            wdata_d       = m1_wdata;
          end else begin
            ctl_d.we      = m0_we;
            ctl_d.is_byte = m0_byte;
            addr_d        = m0_addr;
            wdata_d       = m0_wdata;
          end
          state_d = ARB_ISSUE;
        end
      end
      ARB_ISSUE: begin
        if (ctl_q.we) begin
          state_d = ARB_DONE;
        end else begin
          cnt_d   = CNT_LOAD;
          state_d = ARB_WAIT;
        end
      end
      ARB_WAIT: begin
        if (cnt_q == '0) begin
          rdata_d = mem_rdata;
          state_d = ARB_DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ARB_DONE: begin
        state_d = ARB_IDLE;
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase

    // Outputs are decoded from the next state and registered below.
    mem_en_d = (state_d == ARB_ISSUE);
    mem_we_d = (state_d == ARB_ISSUE) && ctl_d.we;
    m0_ack_d = (state_d == ARB_DONE) && (ctl_d.id == M_CPU);
    m1_ack_d = (state_d == ARB_DONE) && (ctl_d.id == M_DMA);
    busy_d   = (state_d != ARB_IDLE);
  end

  // State, latched fields and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ARB_IDLE;
      ctl_q        <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      cnt_q        <= '0;
      last_grant_q <= M_DMA;
      mem_en       <= 1'b0;
      mem_we       <= 1'b0;
      m0_ack       <= 1'b0;
      m1_ack       <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state_q      <= state_d;
      ctl_q        <= ctl_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      mem_en       <= mem_en_d;
      mem_we       <= mem_we_d;
      m0_ack       <= m0_ack_d;
      m1_ack       <= m1_ack_d;
      busy         <= busy_d;
    end
  end

  assign mem_byte  = ctl_q.is_byte;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign m0_rdata  = rdata_q;
  assign m1_rdata  = rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: three instances (LAT = 2, 1, 15), each
// with a fixed-latency memory model. Stimulus pushes expected memory issues,
// acks and point probes; a negedge monitor pops and compares.
module tb_mem_arbiter;

  localparam int NI = 3;
  localparam int P_BUSY = 0, P_EN = 1, P_WE = 2, P_BYTE = 3, P_ADDR = 4,
                 P_WDATA = 5, P_ACK0 = 6, P_ACK1 = 7, P_RDATA0 = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        m0_req [NI], m0_we [NI], m0_byte [NI], m0_ack [NI];
  logic [31:0] m0_addr [NI], m0_wdata [NI], m0_rdata [NI];
  logic        m1_req [NI], m1_we [NI], m1_byte [NI], m1_ack [NI];
  logic [31:0] m1_addr [NI], m1_wdata [NI], m1_rdata [NI];
  logic        mem_en [NI], mem_we [NI], mem_byte [NI], busy [NI];
  logic [31:0] mem_addr [NI], mem_wdata [NI], mem_rdata [NI];
  logic        hold0 [NI];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory contents seen by reads.
  function automatic logic [31:0] mem_model(input logic [31:0] a);
    case (a)
      32'h20:  return 32'h12345678;
      32'h40:  return 32'hA5A50040;
      32'h80:  return 32'h00008080;
      32'h91:  return 32'h0000C391;
      32'hA3:  return 32'hFEDCBA98;
      default: return 32'hBADC0DE0;
    endcase
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int unsigned L = (g == 0) ? 2 : ((g == 1) ? 1 : 15);

    mem_arbiter #(.AW(32), .DW(32), .LAT(L)) u_dut (
      .clk(clk), .rst(rst),
      .m0_req(m0_req[g]), .m0_we(m0_we[g]), .m0_byte(m0_byte[g]),
      .m0_addr(m0_addr[g]), .m0_wdata(m0_wdata[g]),
      .m0_ack(m0_ack[g]), .m0_rdata(m0_rdata[g]),
      .m1_req(m1_req[g]), .m1_we(m1_we[g]), .m1_byte(m1_byte[g]),
      .m1_addr(m1_addr[g]), .m1_wdata(m1_wdata[g]),
      .m1_ack(m1_ack[g]), .m1_rdata(m1_rdata[g]),
      .mem_en(mem_en[g]), .mem_we(mem_we[g]), .mem_byte(mem_byte[g]),
      .mem_addr(mem_addr[g]), .mem_wdata(mem_wdata[g]),
      .mem_rdata(mem_rdata[g]), .busy(busy[g])
    );

    // Read data appears exactly L cycles after the mem_en cycle, garbage otherwise.
    logic [32:0] pipe [L];
    always @(posedge clk) begin
      if (rst) begin
        for (int k = 0; k < L; k++) pipe[k] <= '0;
      end else begin
        pipe[0] <= {(mem_en[g] && !mem_we[g]), mem_model(mem_addr[g])};
        for (int k = 1; k < L; k++) pipe[k] <= pipe[k-1];
      end
    end
    assign mem_rdata[g] = pipe[L-1][32] ? pipe[L-1][31:0] : 32'hDEAD0000;
  end

  typedef struct {
    int          cyc;
    logic        we;
    logic        byt;
    logic [31:0] addr;
    logic [31:0] wdata;
  } iss_t;
  typedef struct {
    int          cyc;
    logic        m;
    logic [31:0] rdata;
    logic        chk;
  } ack_t;
  typedef struct {
    int          i;
    int          cyc;
    int          sig;
    logic [31:0] val;
  } prb_t;

  iss_t issq [NI][$];
  ack_t ackq [NI][$];
  prb_t prbq [$];

  int   vectors = 0;
  int   miscompares = 0;
  bit   finish_req = 1'b0;
  iss_t e_iss;
  ack_t e_ack;
  prb_t e_prb;

  task automatic cmp(input string nm, input int i, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s inst%0d cyc %0d: got %h expected %h", nm, i, cyc, got, exp);
    end
  endtask

  function automatic string pname(input int s);
    case (s)
      P_BUSY:  return "busy";
      P_EN:    return "mem_en";
      P_WE:    return "mem_we";
      P_BYTE:  return "mem_byte";
      P_ADDR:  return "mem_addr";
      P_WDATA: return "mem_wdata";
      P_ACK0:  return "m0_ack";
      P_ACK1:  return "m1_ack";
      default: return "rdata";
    endcase
  endfunction

  function automatic logic [31:0] pval(input int i, input int s);
    case (s)
      P_BUSY:  return 32'(busy[i]);
      P_EN:    return 32'(mem_en[i]);
      P_WE:    return 32'(mem_we[i]);
      P_BYTE:  return 32'(mem_byte[i]);
      P_ADDR:  return mem_addr[i];
      P_WDATA: return mem_wdata[i];
      P_ACK0:  return 32'(m0_ack[i]);
      P_ACK1:  return 32'(m1_ack[i]);
      default: return m0_rdata[i] | m1_rdata[i];
    endcase
  endfunction

  // Monitor: compares DUT activity against queued expectations.
  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (issq[i].size() > 0 && issq[i][0].cyc < cyc) begin
        e_iss = issq[i].pop_front();
        cmp("mem_en_cycle", i, 32'(cyc), 32'(e_iss.cyc));
      end
      if (mem_en[i] === 1'b1) begin
        if (issq[i].size() == 0) begin
          cmp("mem_en_unexpected", i, 32'(mem_en[i]), 32'd0);
        end else begin
          e_iss = issq[i].pop_front();
          cmp("mem_en_cycle", i, 32'(cyc), 32'(e_iss.cyc));
          cmp("mem_we", i, 32'(mem_we[i]), 32'(e_iss.we));
          cmp("mem_byte", i, 32'(mem_byte[i]), 32'(e_iss.byt));
          cmp("mem_addr", i, mem_addr[i], e_iss.addr);
          if (e_iss.we) cmp("mem_wdata", i, mem_wdata[i], e_iss.wdata);
        end
      end
      if (mem_we[i] === 1'b1) cmp("mem_we_without_en", i, 32'(mem_en[i]), 32'd1);

      if (ackq[i].size() > 0 && ackq[i][0].cyc < cyc) begin
        e_ack = ackq[i].pop_front();
        cmp("ack_cycle", i, 32'(cyc), 32'(e_ack.cyc));
      end
      for (int m = 0; m < 2; m++) begin
        if (((m == 1) ? m1_ack[i] : m0_ack[i]) === 1'b1) begin
          if (ackq[i].size() == 0) begin
            cmp("ack_unexpected", i, 32'(m), 32'hFFFFFFFF);
          end else begin
            e_ack = ackq[i].pop_front();
            cmp("ack_master", i, 32'(m), 32'(e_ack.m));
            cmp("ack_cycle", i, 32'(cyc), 32'(e_ack.cyc));
            if (e_ack.chk)
              cmp("ack_rdata", i, (m == 1) ? m1_rdata[i] : m0_rdata[i], e_ack.rdata);
          end
        end
      end
    end

    while (prbq.size() > 0 && prbq[0].cyc <= cyc) begin
      e_prb = prbq.pop_front();
      cmp(pname(e_prb.sig), e_prb.i, pval(e_prb.i, e_prb.sig), e_prb.val);
    end

    if (cyc > 3000) begin
      miscompares++;
      $display("FAIL timeout: cycle %0d exceeded budget 3000", cyc);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
    end

    if (finish_req) begin
      for (int i = 0; i < NI; i++) begin
        cmp("issue_pending", i, 32'(issq[i].size()), 32'd0);
        cmp("ack_pending", i, 32'(ackq[i].size()), 32'd0);
      end
      cmp("probe_pending", 0, 32'(prbq.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic exp_iss(input int i, input int c, input logic we, input logic byt,
                         input logic [31:0] a, input logic [31:0] d);
    iss_t e;
    e.cyc = c; e.we = we; e.byt = byt; e.addr = a; e.wdata = d;
    issq[i].push_back(e);
  endtask

  task automatic exp_ack(input int i, input logic m, input int c,
                         input logic [31:0] rd, input logic chk);
    ack_t e;
    e.cyc = c; e.m = m; e.rdata = rd; e.chk = chk;
    ackq[i].push_back(e);
  endtask

  task automatic probe(input int i, input int c, input int s, input logic [31:0] v);
    prb_t p;
    p.i = i; p.cyc = c; p.sig = s; p.val = v;
    prbq.push_back(p);
  endtask

  task automatic req(input int i, input logic m, input logic we, input logic byt,
                     input logic [31:0] a, input logic [31:0] d);
    if (m) begin
      m1_we[i] = we; m1_byte[i] = byt; m1_addr[i] = a; m1_wdata[i] = d; m1_req[i] = 1'b1;
    end else begin
      m0_we[i] = we; m0_byte[i] = byt; m0_addr[i] = a; m0_wdata[i] = d; m0_req[i] = 1'b1;
    end
  endtask

  // One cycle: masters drop req in the cycle after they see their ack.
  task automatic step();
    logic a0 [NI];
    logic a1 [NI];
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      a0[i] = m0_ack[i];
      a1[i] = m1_ack[i];
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) begin
      if (a0[i] === 1'b1 && !hold0[i]) m0_req[i] = 1'b0;
      if (a1[i] === 1'b1) m1_req[i] = 1'b0;
    end
  endtask

  function automatic bit any_req();
    bit r = 1'b0;
    for (int i = 0; i < NI; i++) r = r | m0_req[i] | m1_req[i];
    return r;
  endfunction

  task automatic drain();
    int n = 0;
    while (any_req() && n < 200) begin
      step();
      n++;
    end
    for (int i = 0; i < NI; i++) begin
      m0_req[i] = 1'b0;
      m1_req[i] = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int t;
    rst = 1'b1;
    for (int i = 0; i < NI; i++) begin
      m0_req[i] = 0; m0_we[i] = 0; m0_byte[i] = 0; m0_addr[i] = 0; m0_wdata[i] = 0;
      m1_req[i] = 0; m1_we[i] = 0; m1_byte[i] = 0; m1_addr[i] = 0; m1_wdata[i] = 0;
      hold0[i] = 0;
    end
    @(posedge clk);
    #1;
    // Reset values.
    for (int i = 0; i < NI; i++)
      for (int s = P_BUSY; s <= P_RDATA0; s++) probe(i, 2, s, 32'd0);
    idle(2);
    rst = 1'b0;
    idle(1);

    // m0 write; m1 must stay silent.
    t = cyc;
    req(0, 1'b0, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF);
    exp_iss(0, t + 1, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF);
    exp_ack(0, 1'b0, t + 2, 32'h0, 1'b0);
    drain();
    idle(2);

    // m1 read, LAT=2: ack at T+4, busy over T+1..T+4.
    t = cyc;
    req(0, 1'b1, 1'b0, 1'b0, 32'h20, 32'h0);
    exp_iss(0, t + 1, 1'b0, 1'b0, 32'h20, 32'h0);
    exp_ack(0, 1'b1, t + 4, 32'h12345678, 1'b1);
    for (int k = 0; k <= 5; k++) probe(0, t + k, P_BUSY, 32'((k >= 1) && (k <= 4)));
    idle(5);
    drain();
    idle(2);

    // Tie from reset: m0 first; m0 re-requesting at once loses to the held m1.
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    t = cyc;
    hold0[0] = 1'b1;
    req(0, 1'b0, 1'b1, 1'b0, 32'h30, 32'h11111111);
    req(0, 1'b1, 1'b0, 1'b0, 32'h40, 32'h0);
    exp_iss(0, t + 1, 1'b1, 1'b0, 32'h30, 32'h11111111);
    exp_ack(0, 1'b0, t + 2, 32'h0, 1'b0);
    exp_iss(0, t + 4, 1'b0, 1'b0, 32'h40, 32'h0);
    exp_ack(0, 1'b1, t + 7, 32'hA5A50040, 1'b1);
    exp_iss(0, t + 9, 1'b1, 1'b0, 32'h30, 32'h11111111);
    exp_ack(0, 1'b0, t + 10, 32'h0, 1'b0);
    idle(8);
    hold0[0] = 1'b0;
    drain();
    idle(2);

    // m0 back-to-back writes with one IDLE gap; m1 cuts in before m0's next.
    t = cyc;
    hold0[0] = 1'b1;
    req(0, 1'b0, 1'b1, 1'b0, 32'h50, 32'hCAFE0001);
    exp_iss(0, t + 1, 1'b1, 1'b0, 32'h50, 32'hCAFE0001);
    exp_ack(0, 1'b0, t + 2, 32'h0, 1'b0);
    exp_iss(0, t + 4, 1'b1, 1'b0, 32'h50, 32'hCAFE0001);
    exp_ack(0, 1'b0, t + 5, 32'h0, 1'b0);
    exp_iss(0, t + 7, 1'b1, 1'b0, 32'h50, 32'hCAFE0001);
    exp_ack(0, 1'b0, t + 8, 32'h0, 1'b0);
    exp_iss(0, t + 10, 1'b1, 1'b0, 32'h60, 32'h0BADF00D);
    exp_ack(0, 1'b1, t + 11, 32'h0, 1'b0);
    exp_iss(0, t + 13, 1'b1, 1'b0, 32'h50, 32'hCAFE0001);
    exp_ack(0, 1'b0, t + 14, 32'h0, 1'b0);
    probe(0, t + 3, P_BUSY, 32'd0);
    probe(0, t + 6, P_BUSY, 32'd0);
    idle(7);
    req(0, 1'b1, 1'b1, 1'b0, 32'h60, 32'h0BADF00D);
    idle(2);
    hold0[0] = 1'b0;
    drain();
    idle(2);

    // Reset during WAIT: no ack, idle and quiet next cycle; then a clean read.
    t = cyc;
    req(0, 1'b0, 1'b0, 1'b0, 32'h70, 32'h0);
    exp_iss(0, t + 1, 1'b0, 1'b0, 32'h70, 32'h0);
    probe(0, t + 3, P_BUSY, 32'd0);
    probe(0, t + 3, P_EN, 32'd0);
    probe(0, t + 3, P_ACK0, 32'd0);
    probe(0, t + 4, P_ACK0, 32'd0);
    probe(0, t + 4, P_BUSY, 32'd0);
    idle(2);
    rst = 1'b1;
    m0_req[0] = 1'b0;
    idle(1);
    rst = 1'b0;
    idle(2);
    t = cyc;
    req(0, 1'b0, 1'b0, 1'b0, 32'h80, 32'h0);
    exp_iss(0, t + 1, 1'b0, 1'b0, 32'h80, 32'h0);
    exp_ack(0, 1'b0, t + 4, 32'h00008080, 1'b1);
    drain();
    idle(2);

    // Byte reads on LAT=1 and LAT=15 builds.
    t = cyc;
    req(1, 1'b0, 1'b0, 1'b1, 32'h91, 32'h0);
    req(2, 1'b0, 1'b0, 1'b1, 32'hA3, 32'h0);
    exp_iss(1, t + 1, 1'b0, 1'b1, 32'h91, 32'h0);
    exp_ack(1, 1'b0, t + 3, 32'h0000C391, 1'b1);
    exp_iss(2, t + 1, 1'b0, 1'b1, 32'hA3, 32'h0);
    exp_ack(2, 1'b0, t + 17, 32'hFEDCBA98, 1'b1);
    drain();
    idle(3);

    finish_req = 1'b1;
  end

endmodule
